add_32bit_seq: RTL and testbench

Byte-serial 32-bit signed adder for the MiniMIPS datapath: the addition-side counterpart to the combinational 32-bit subtractor. It accepts two 32-bit operands over a valid/ready handshake and adds them one byte per cycle through a single 8-bit slice, rippling the carry in a register. It returns the 32-bit result, carry-out and signed-overflow flag over a second valid/ready handshake. It is the multi-cycle ALU add path, where area matters more than latency.

---
 rtl/add_32bit_seq_pkg.sv | 21 ++
 rtl/add_32bit_seq_if.sv | 30 +++
 rtl/add_32bit_seq_slice.sv | 27 ++
 rtl/add_32bit_seq.sv | 109 ++++++++++
 tb/tb_add_32bit_seq.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/add_32bit_seq_pkg.sv
// Shared constants and types for the MiniMIPS multi-cycle ALU add path.
// Imported by the add_32bit_seq interface, slice adder and top.
package minimips_alu_pkg;

  localparam int ALU_WIDTH  = 32;
  localparam int ALU_SLICE  = 8;
  localparam int ALU_SLICES = ALU_WIDTH / ALU_SLICE;
  localparam int ALU_CNT_W  = $clog2(ALU_SLICES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // Slice-counter width that stays legal even for a single-slice build.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_32bit_seq_if.sv
// Operand/result handshake bundle for add_32bit_seq.
// master = operand producer / result consumer, slave = the adder.
interface add_32bit_seq_if
  import minimips_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] value1;
  logic [WIDTH-1:0] value2;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, value1, value2, sub, out_ready,
    input  in_ready, out_valid, result, carry, overflow
  );

  modport slave (
    input  in_valid, value1, value2, sub, out_ready,
    output in_ready, out_valid, result, carry, overflow
  );

endinterface

// File: rtl/add_32bit_seq_slice.sv
// Combinational SLICE-bit adder; also exposes the carry into its MSB so the
// top can form the signed-overflow flag on the last slice.
module add_slice
  import minimips_alu_pkg::*;
#(
  parameter int SLICE = ALU_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE-1:0] low;
  logic [1:0]       top;

  // Low bits are summed in a SLICE-wide field so the top bit is the MSB carry-in.
  assign low = {1'b0, a[SLICE-2:0]} + {1'b0, b[SLICE-2:0]} + {{(SLICE-1){1'b0}}, cin};
  assign top = {1'b0, a[SLICE-1]} + {1'b0, b[SLICE-1]} + {1'b0, low[SLICE-1]};

  assign sum   = {top[0], low[SLICE-2:0]};
  assign cout  = top[1];
  assign c_msb = low[SLICE-1];

endmodule

// File: rtl/add_32bit_seq.sv
// Byte-serial signed adder: one SLICE-bit slice per cycle, carry rippled in a
// register. Define ADD_SEQ_SUB_EN to enable subtraction via the sub input.
module add_32bit_seq
  import minimips_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SLICE = ALU_SLICE
) (
  input logic                 clk,
  input logic                 rst_n,
  add_32bit_seq_if.slave      bus
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int CNT_W   = cnt_width(NSLICES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICES - 1);

  alu_state_t       state_q, state_next;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_out_q;
  logic             overflow_q;

  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;

  // Handshake flags come straight from the state register.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.carry     = carry_out_q;
  assign bus.overflow  = overflow_q;

`ifdef ADD_SEQ_SUB_EN
  assign b_in   = bus.sub ? ~bus.value2 : bus.value2;
  assign cin_in = bus.sub;
`else
  assign b_in   = bus.value2;
  assign cin_in = 1'b0;
`endif

  add_slice #(.SLICE(SLICE)) u_slice (
    .a     (a_q[int'(cnt_q)*SLICE +: SLICE]),
    .b     (b_q[int'(cnt_q)*SLICE +: SLICE]),
    .cin   (carry_q),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_next;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)    state_next = BUSY;
      BUSY:    if (cnt_q == LAST)   state_next = DONE;
      DONE:    if (bus.out_ready)   state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // NOTE: operand registers are reset alongside the visible outputs so a
  // reset mid-operation leaves no stale data to leak into the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.value1;
            b_q     <= b_in;
            carry_q <= cin_in;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          result_q[int'(cnt_q)*SLICE +: SLICE] <= slice_sum;
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            carry_out_q <= slice_cout;
            overflow_q  <= slice_cmsb ^ slice_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_32bit_seq.sv
// Self-checking bench for add_32bit_seq: directed cases plus random operations
// checked against an arithmetic reference model.
module tb_add_32bit_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  add_32bit_seq_if #(.WIDTH(32)) bus ();

  add_32bit_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: full-width arithmetic on the (optionally inverted) operands.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] r, output logic c, output logic v);
    logic [32:0] full;
    logic [31:0] bb;
    logic        do_sub;
`ifdef ADD_SEQ_SUB_EN
    do_sub = s;
`else
    do_sub = 1'b0;
`endif
    bb   = do_sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {32'd0, do_sub};
    r    = full[31:0];
    c    = full[32];
    v    = (a[31] == bb[31]) && (r[31] != a[31]);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int hold, input string tag);
    logic [31:0] er;
    logic        ec, ev;
    int          cyc;
    model(a, b, s, er, ec, ev);
    check({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.value1    = a;
    bus.value2    = b;
    bus.sub       = s;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.value1   = $urandom;
    bus.value2   = $urandom;
    bus.sub      = 1'($urandom);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, cyc, 32'd4);
    check({tag, ".result"},   bus.result, er);
    check({tag, ".carry"},    {31'd0, bus.carry}, {31'd0, ec});
    check({tag, ".overflow"}, {31'd0, bus.overflow}, {31'd0, ev});
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.value1   = $urandom;
      bus.value2   = $urandom;
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({tag, ".hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      check({tag, ".hold_result"}, bus.result, er);
      check({tag, ".hold_flags"}, {30'd0, bus.carry, bus.overflow}, {30'd0, ec, ev});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check({tag, ".consumed"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    bus.in_valid  = 1'b0;
    bus.value1    = '0;
    bus.value2    = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("reset.outs", {bus.result[28:0], bus.carry, bus.overflow, bus.out_valid}, 32'd0);
    check("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(32'd222222, 32'd200000, 1'b0, 0, "dec_add");
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, "pos_ovf");
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1, "neg_ovf");
    do_op(32'hFFFF_FFFE, 32'h5555_5555, 1'b0, 10, "stall");

    // Asynchronous reset during the second BUSY cycle.
    bus.value1   = 32'h1234_5678;
    bus.value2   = 32'h0F0F_0F0F;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset.result", bus.result, 32'd0);
    check("midreset.flags", {29'd0, bus.carry, bus.overflow, bus.out_valid}, 32'd0);
    check("midreset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'd100000000, 32'd200000000, 1'b0, 0, "after_reset");

    // Subtract requests; with the feature off these must add.
    do_op(32'd1, 32'd2, 1'b1, 0, "sub_1_2");
    do_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 2, "sub_ovf");

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 6 == 0) ra = 32'h7FFF_FFFF;
      if (n % 6 == 1) rb = 32'hFFFF_FFFF;
      do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
